// File: rtl/sram_resp_model_pkg.sv
// Shared widths and the rdata source selector for the SRAM responder.
package sram_resp_model_pkg;

  localparam int SRAM_DATA_WD = 32;
  localparam int SRAM_ADDR_WD = 32;
  localparam int SRAM_WEN_WD  = 4;

  // Where the visible rdata comes from since the last accepted access.
  typedef enum logic [1:0] {
    RD_SRC_RESET = 2'd0,
    RD_SRC_ZERO  = 2'd1,
    RD_SRC_BANK  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/sram_bank.sv
// Byte-lane storage with a registered read port; one 8-bit array per lane.
// Read-first by default; define SRAM_WRITE_FIRST_EN for write-first readback.
module sram_bank
  import sram_resp_model_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [SRAM_WEN_WD-1:0]  wen,
  input  logic [DEPTH_LOG2-1:0]   idx,
  input  logic [SRAM_DATA_WD-1:0] wdata,
  output logic [SRAM_DATA_WD-1:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  genvar gi;
  generate
    for (gi = 0; gi < SRAM_WEN_WD; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (en) begin
          if (wen[gi]) begin
            mem[idx] <= wdata[8*gi +: 8];
          end
`ifdef SRAM_WRITE_FIRST_EN
          rdata_reg <= wen[gi] ? wdata[8*gi +: 8] : mem[idx];
`else
          rdata_reg <= mem[idx];
`endif
        end
      end

      assign rdata[8*gi +: 8] = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/sram_resp_model.sv
// SRAM responder: address decode, sticky out-of-range flag, saturating
// access counters and reset/zero muxing around sram_bank. Option: SRAM_WRITE_FIRST_EN.
module sram_resp_model
  import sram_resp_model_pkg::*;
#(
  parameter int                      DEPTH_LOG2  = 14,
  parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [SRAM_DATA_WD-1:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sram_en,
  input  logic [SRAM_WEN_WD-1:0]  sram_wen,
  input  logic [SRAM_ADDR_WD-1:0] sram_addr,
  input  logic [SRAM_DATA_WD-1:0] sram_wdata,
  output logic [SRAM_DATA_WD-1:0] sram_rdata,
  output logic                    err_oor,
  output logic [31:0]             rd_cnt,
  output logic [31:0]             wr_cnt
);

  logic [SRAM_ADDR_WD-1:0] off;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [1:0]              unused_addr_bits;
  logic                    is_rd;
  logic                    is_wr;
  logic                    bank_en;
  logic [SRAM_DATA_WD-1:0] bank_rdata;

  rd_src_e     rd_src_reg, rd_src_next;
  logic        err_oor_reg, err_oor_next;
  logic [31:0] rd_cnt_reg, rd_cnt_next;
  logic [31:0] wr_cnt_reg, wr_cnt_next;

  assign off              = sram_addr - BASE_ADDR;
  assign in_range         = (off[SRAM_ADDR_WD-1:DEPTH_LOG2+2] == '0);
  assign idx              = off[DEPTH_LOG2+1:2];
  assign unused_addr_bits = off[1:0];

  assign is_rd   = sram_en && in_range && (sram_wen == '0);
  assign is_wr   = sram_en && in_range && (sram_wen != '0);
  // Reset must also suppress the array write, not just the status registers.
  assign bank_en = sram_en && in_range && !reset;

  sram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk  (clk),
    .en   (bank_en),
    .wen  (sram_wen),
    .idx  (idx),
    .wdata(sram_wdata),
    .rdata(bank_rdata)
  );

  always_comb begin
    rd_src_next  = rd_src_reg;
    err_oor_next = err_oor_reg;
    rd_cnt_next  = rd_cnt_reg;
    wr_cnt_next  = wr_cnt_reg;
    if (sram_en) begin
      if (in_range) begin
        rd_src_next = RD_SRC_BANK;
      end else begin
        rd_src_next  = RD_SRC_ZERO;
        err_oor_next = 1'b1;
      end
    end
    if (is_rd && (rd_cnt_reg != 32'hFFFF_FFFF)) begin
      rd_cnt_next = rd_cnt_reg + 32'd1;
    end
    if (is_wr && (wr_cnt_reg != 32'hFFFF_FFFF)) begin
      wr_cnt_next = wr_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_src_reg  <= RD_SRC_RESET;
      err_oor_reg <= 1'b0;
      rd_cnt_reg  <= '0;
      wr_cnt_reg  <= '0;
    end else begin
      rd_src_reg  <= rd_src_next;
      err_oor_reg <= err_oor_next;
      rd_cnt_reg  <= rd_cnt_next;
      wr_cnt_reg  <= wr_cnt_next;
    end
  end

  // The bank register only moves on in-range accesses, so idle cycles hold.
  always_comb begin
    sram_rdata = RESET_RDATA;
    case (rd_src_reg)
      RD_SRC_ZERO: sram_rdata = '0;
      RD_SRC_BANK: sram_rdata = bank_rdata;
      default:     sram_rdata = RESET_RDATA;
    endcase
  end

  assign err_oor = err_oor_reg;
  assign rd_cnt  = rd_cnt_reg;
  assign wr_cnt  = wr_cnt_reg;

endmodule

// File: tb/tb_sram_resp_model.sv
// Self-checking bench for sram_resp_model: directed scenarios plus random
// traffic against a word-array reference model.
module tb_sram_resp_model;

  localparam int          DL2       = 4;
  localparam int          NWORDS    = 1 << DL2;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [31:0] RST_RDATA = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;
  logic        err_oor;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always #5 clk = ~clk;

  sram_resp_model #(
    .DEPTH_LOG2 (DL2),
    .BASE_ADDR  (BASE),
    .RESET_RDATA(RST_RDATA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sram_en   (sram_en),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .err_oor   (err_oor),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  // Reference model state
  logic [31:0] ref_mem [NWORDS];
  logic [31:0] ref_rdata;
  logic        ref_err;
  longint      ref_rd;
  longint      ref_wr;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic rst, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    int          idx;
    logic [31:0] old_w, new_w;
    if (rst) begin
      ref_rdata = RST_RDATA;
      ref_err   = 1'b0;
      ref_rd    = 0;
      ref_wr    = 0;
    end else if (en) begin
      off = addr - BASE;
      if (off >= (32'd4 << DL2)) begin
        ref_rdata = 32'h0;
        ref_err   = 1'b1;
      end else begin
        idx   = int'(off / 4);
        old_w = ref_mem[idx];
        if (wen == 4'h0) begin
          ref_rdata = old_w;
          if (ref_rd < 64'hFFFF_FFFF) ref_rd++;
        end else begin
          new_w = old_w;
          for (int b = 0; b < 4; b++)
            if (wen[b]) new_w[8*b +: 8] = wdata[8*b +: 8];
          ref_mem[idx] = new_w;
`ifdef SRAM_WRITE_FIRST_EN
          ref_rdata = new_w;
`else
          ref_rdata = old_w;
`endif
          if (ref_wr < 64'hFFFF_FFFF) ref_wr++;
        end
      end
    end
  endtask

  // Drive at negedge, let one posedge pass, compare everything against the model.
  task automatic step(input logic rst, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
    reset      = rst;
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    @(posedge clk);
    #1;
    model(rst, en, wen, addr, wdata);
    check("rdata", sram_rdata, ref_rdata);
    check("err_oor", {31'b0, err_oor}, {31'b0, ref_err});
    check("rd_cnt", rd_cnt, ref_rd[31:0]);
    check("wr_cnt", wr_cnt, ref_wr[31:0]);
    $display("vec rst=%0b en=%0b wen=%h addr=%h wdata=%h -> rdata=%h err=%0b rd=%0d wr=%0d",
             rst, en, wen, addr, wdata, sram_rdata, err_oor, rd_cnt, wr_cnt);
    @(negedge clk);
    reset   = 1'b0;
    sram_en = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [31:0] a;
  logic [3:0]  w;

  initial begin
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = 32'h0;
    ref_rdata = RST_RDATA;
    ref_err   = 1'b0;
    ref_rd    = 0;
    ref_wr    = 0;
    @(negedge clk);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    check("reset_rdata", sram_rdata, RST_RDATA);

    // Fill the array so no uninitialised word is ever read.
    for (int i = 0; i < NWORDS; i++)
      step(1'b0, 1'b1, 4'hF, BASE + 32'(i * 4), $urandom);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

    // 1: full write then read of word 0
    step(1'b0, 1'b1, 4'hF, BASE, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 4'h0, BASE, 32'h0);
    check("t1_rdata", sram_rdata, 32'hDEAD_BEEF);
    check("t1_rd_cnt", rd_cnt, 32'd1);
    check("t1_wr_cnt", wr_cnt, 32'd1);

    // 2: partial lane write
    step(1'b0, 1'b1, 4'hF, BASE + 32'h10, 32'h1122_3344);
    step(1'b0, 1'b1, 4'h4, BASE + 32'h10, 32'hAABB_CCDD);
    step(1'b0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
    check("t2_merge", sram_rdata, 32'h11BB_3344);

    // 3: readback on the write cycle itself
    step(1'b0, 1'b1, 4'hF, BASE + 32'h20, 32'h0);
    step(1'b0, 1'b1, 4'hF, BASE + 32'h20, 32'h55);
`ifdef SRAM_WRITE_FIRST_EN
    check("t3_wr_rdata", sram_rdata, 32'h55);
`else
    check("t3_wr_rdata", sram_rdata, 32'h0);
`endif

    // 4: out of range read and aliasing write
    step(1'b0, 1'b1, 4'h0, BASE + (32'd4 << DL2), 32'h0);
    check("t4_oor_rdata", sram_rdata, 32'h0);
    check("t4_err", {31'b0, err_oor}, 32'd1);
    step(1'b0, 1'b1, 4'hF, BASE + (32'd4 << DL2), 32'h0BAD_0BAD);
    step(1'b0, 1'b1, 4'hF, BASE - 32'd4, 32'h0BAD_0BAD);
    step(1'b0, 1'b1, 4'h0, BASE, 32'h0);
    check("t4_alias", sram_rdata, 32'hDEAD_BEEF);
    check("t4_err_sticky", {31'b0, err_oor}, 32'd1);

    // 5: pipelined reads then idle hold
    step(1'b0, 1'b1, 4'h0, BASE + 32'h0, 32'h0);
    step(1'b0, 1'b1, 4'h0, BASE + 32'h4, 32'h0);
    step(1'b0, 1'b1, 4'h0, BASE + 32'h8, 32'h0);
    idle();
    idle();
    check("t5_hold", sram_rdata, ref_mem[2]);

    // 6: reset colliding with a write
    step(1'b1, 1'b1, 4'hF, BASE + 32'h10, 32'hFFFF_FFFF);
    check("t6_rdata", sram_rdata, RST_RDATA);
    check("t6_cnt", rd_cnt | wr_cnt, 32'h0);
    idle();
    check("t6_idle_rdata", sram_rdata, RST_RDATA);
    step(1'b0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
    check("t6_word", sram_rdata, 32'h11BB_3344);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? BASE + (32'd4 << DL2) + 32'($urandom_range(0, 255))
                                        : BASE - 32'($urandom_range(1, 64));
      else
        a = BASE + 32'($urandom_range(0, NWORDS - 1) * 4) + 32'($urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), w, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
